// File: rtl/floating_point_tlast_tuser_chk.sv
// Frame checker for a floating-point core's AXI-Stream output: compares each
// beat's tuser against an external ROM and its tlast against the final index.
module floating_point_tlast_tuser_chk #(
    parameter int DEPTH  = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rom_dout,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [7:0]        s_axis_tuser,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    // state  | meaning
    // IDLE   | waiting for start; verdict of the last frame held
    // FETCH  | one-cycle wait for rom_dout to follow rd_addr
    // ARMED  | tready high, waiting for the beat at rd_addr
    // FINISH | one-cycle done pulse, verdict already registered
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ARMED  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t state;
    state_t state_nxt;
    logic   beat_acc;
    logic   last_idx;
    logic   mismatch;

    assign beat_acc = (state == ARMED) && s_axis_tvalid;
    assign last_idx = (rd_addr == LAST_ADDR);
    // tuser and tlast errors on the same beat fold into a single mismatch
    assign mismatch = (s_axis_tuser != rom_dout) || (s_axis_tlast != last_idx);

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                busy      = 1'b1;
                state_nxt = ARMED;
            end
            ARMED: begin
                busy          = 1'b1;
                s_axis_tready = 1'b1;
                if (beat_acc) state_nxt = last_idx ? FINISH : FETCH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rd_addr        <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                rd_addr        <= '0;
                err_cnt        <= '0;
                first_err_addr <= '0;
                pass           <= 1'b0;
            end else if (beat_acc) begin
                if (mismatch) begin
                    // err_cnt saturates, so zero means no earlier mismatch
                    if (err_cnt == 8'd0) first_err_addr <= rd_addr;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
                if (last_idx) begin
                    // verdict lands with done, so it includes the final beat
                    pass <= !mismatch && (err_cnt == 8'd0);
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_floating_point_tlast_tuser_chk.sv
// Self-checking bench: transaction-level model of the frame checker compared
// against the DUT every cycle, plus directed literal checks of frame verdicts.
module tb_floating_point_tlast_tuser_chk;

    localparam int DEPTH  = 10;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rom_dout = 8'd0;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [7:0]        s_axis_tuser;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        err_cnt;
    logic [ADDR_W-1:0] first_err_addr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rom [0:15] = '{8'h90, 8'h81, 8'h72, 8'h63, 8'h54, 8'h45, 8'h36, 8'h27,
                               8'h18, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    floating_point_tlast_tuser_chk #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .rd_addr        (rd_addr),
        .rom_dout       (rom_dout),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom[rd_addr];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: frame in progress, beat index, waiting-for-ROM phase.
    logic m_busy = 1'b0, m_fetch = 1'b0, m_fin = 1'b0, m_pass = 1'b0;
    int   m_idx = 0, m_err = 0, m_first = 0;

    always @(posedge clk) begin : model
        logic bad;
        int   e;
        if (rst) begin
            m_busy <= 1'b0; m_fetch <= 1'b0; m_fin <= 1'b0; m_pass <= 1'b0;
            m_idx <= 0; m_err <= 0; m_first <= 0;
        end else if (m_fin) begin
            m_fin <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1; m_fetch <= 1'b1; m_pass <= 1'b0;
                m_idx <= 0; m_err <= 0; m_first <= 0;
            end
        end else if (m_fetch) begin
            m_fetch <= 1'b0;
        end else if (s_axis_tvalid) begin
            bad = (s_axis_tuser != rom[m_idx]) || (s_axis_tlast != (m_idx == DEPTH - 1));
            e = m_err;
            if (bad) begin
                if (m_err == 0) m_first <= m_idx;
                if (m_err < 255) e = m_err + 1;
            end
            m_err <= e;
            if (m_idx == DEPTH - 1) begin
                m_busy <= 1'b0; m_fin <= 1'b1; m_pass <= (e == 0);
            end else begin
                m_idx <= m_idx + 1; m_fetch <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("tready", int'(s_axis_tready), int'(m_busy && !m_fetch));
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_fin));
        chk("rd_addr", int'(rd_addr), m_idx);
        chk("err_cnt", int'(err_cnt), m_err);
        chk("first_err_addr", int'(first_err_addr), m_first);
        chk("pass", int'(pass), int'(m_pass));
    end

    // Drives one frame; returns negedges from the start pulse until done (or -1 on abort).
    task automatic run_frame(input logic [9:0] bad_user, input logic [9:0] last_pat,
                             input bit gaps, input int rst_at, input bit spam,
                             output int cyc);
        int k   = 0;
        int gap = gaps ? int'($urandom_range(0, 5)) : 0;
        bit acc_prev = 1'b0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1; s_axis_tvalid = 1'b0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (acc_prev) begin
                k++;
                gap = gaps ? int'($urandom_range(0, 5)) : 0;
            end
            if (done) break;
            if (rst_at >= 0 && k == rst_at) begin
                rst = 1'b1; start = 1'b1; s_axis_tvalid = 1'b1;
                s_axis_tuser = rom[k]; s_axis_tlast = 1'b0;
                @(negedge clk);
                rst = 1'b0; start = 1'b0; s_axis_tvalid = 1'b0;
                chk("abort_rd_addr", int'(rd_addr), 0);
                chk("abort_err_cnt", int'(err_cnt), 0);
                chk("abort_busy", int'(busy), 0);
                cyc = -1;
                return;
            end
            start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gap > 0) begin
                gap--;
                s_axis_tvalid = 1'b0;
                s_axis_tuser  = 8'($urandom);
                s_axis_tlast  = 1'($urandom);
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tuser  = bad_user[k] ? 8'h00 : rom[k];
                s_axis_tlast  = last_pat[k];
            end
            acc_prev = s_axis_tvalid && s_axis_tready;
        end
        if (cyc >= 400) chk("frame_timeout", cyc, 0);
        start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [9:0] bu, lp;
        rst = 1'b1; start = 1'b0; s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0; s_axis_tuser = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tready", int'(s_axis_tready), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;

        // stray tvalid while idle must be ignored
        repeat (4) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1; s_axis_tuser = 8'($urandom); s_axis_tlast = 1'b1;
        end
        @(negedge clk); s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

        // golden frame, back-to-back beats: done 20 edges after the start edge
        run_frame(10'h000, 10'h200, 1'b0, -1, 1'b0, cyc);
        chk("golden_latency", cyc, 21);
        chk("golden_pass", int'(pass), 1);
        chk("golden_err_cnt", int'(err_cnt), 0);
        chk("golden_first", int'(first_err_addr), 0);
        repeat (2) @(negedge clk);
        chk("golden_pass_held", int'(pass), 1);

        run_frame(10'h008, 10'h200, 1'b0, -1, 1'b0, cyc);
        chk("tuser3_err_cnt", int'(err_cnt), 1);
        chk("tuser3_first", int'(first_err_addr), 3);
        chk("tuser3_pass", int'(pass), 0);

        run_frame(10'h000, 10'h010, 1'b0, -1, 1'b0, cyc);
        chk("tlast4_err_cnt", int'(err_cnt), 2);
        chk("tlast4_first", int'(first_err_addr), 4);
        chk("tlast4_pass", int'(pass), 0);
        chk("tlast4_ran_full", cyc, 21);

        run_frame(10'h000, 10'h200, 1'b1, -1, 1'b0, cyc);
        chk("gaps_pass", int'(pass), 1);
        chk("gaps_err_cnt", int'(err_cnt), 0);

        run_frame(10'h006, 10'h200, 1'b0, 5, 1'b0, cyc);
        chk("abort_no_done", cyc, -1);
        run_frame(10'h000, 10'h200, 1'b0, -1, 1'b0, cyc);
        chk("after_abort_latency", cyc, 21);
        chk("after_abort_err_cnt", int'(err_cnt), 0);
        chk("after_abort_pass", int'(pass), 1);

        run_frame(10'h3FF, 10'h200, 1'b1, -1, 1'b1, cyc);
        chk("spam_err_cnt", int'(err_cnt), 10);
        chk("spam_first", int'(first_err_addr), 0);
        chk("spam_pass", int'(pass), 0);

        repeat (12) begin
            bu = ($urandom_range(0, 1) == 1) ? (10'($urandom) & 10'($urandom)) : 10'h000;
            lp = 10'h200;
            if ($urandom_range(0, 2) == 0) lp = lp ^ (10'd1 << $urandom_range(0, 9));
            run_frame(bu, lp, 1'($urandom), -1, 1'($urandom), cyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/floating_point_tlast_tuser_chk.md
FLOATING_POINT_TLAST_TUSER_CHK -- requirements
Module: floating_point_tlast_tuser_chk

Interface
REQ-001 SHALL have parameter DEPTH, default 10, meaning number of expected beats per frame (ROM entries 0..DEPTH-1).
REQ-002 SHALL have parameter ADDR_W, default 4, meaning width of the expected-value ROM address.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle pulse that begins one frame check.
REQ-006 SHALL have port rd_addr, output, ADDR_W, address to the external expected-value ROM.
REQ-007 SHALL have port rom_dout, input, 8, ROM data, valid one clk after rd_addr is presented.
REQ-008 SHALL have port s_axis_tvalid, input, 1, beat valid from the floating-point core output.
REQ-009 SHALL have port s_axis_tready, output, 1, checker ready to accept a beat.
REQ-010 SHALL have port s_axis_tlast, input, 1, end-of-frame flag under test.
REQ-011 SHALL have port s_axis_tuser, input, 8, sideband value under test.
REQ-012 SHALL have port busy, output, 1, high from accepted start until done.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when the last beat has been checked.
REQ-014 SHALL have port pass, output, 1, registered verdict, valid from done until the next accepted start.
REQ-015 SHALL have port err_cnt, output, 8, count of mismatched beats in the current/last frame.
REQ-016 SHALL have port first_err_addr, output, ADDR_W, index of the first mismatched beat.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, ARMED, FINISH.
REQ-018 IDLE: start=1 SHALL clear err_cnt, first_err_addr, pass; set rd_addr=0; go FETCH; busy=1 from next cycle.
REQ-019 FETCH SHALL last exactly one cycle (ROM latency), then go ARMED; s_axis_tready=0 in FETCH.
REQ-020 ARMED SHALL drive s_axis_tready=1; a beat is accepted only when s_axis_tvalid and s_axis_tready are both 1.
REQ-021 On an accepted beat, expected tuser SHALL be rom_dout, and expected tlast SHALL be 1 iff rd_addr==DEPTH-1.
REQ-022 A beat SHALL count as one mismatch if tuser differs, tlast differs, or both (never +2 for one beat).
REQ-023 err_cnt SHALL saturate at 255.
REQ-024 first_err_addr SHALL capture rd_addr at the first mismatch only; remains 0 if no mismatch.
REQ-025 After an accepted beat with rd_addr<DEPTH-1: rd_addr increments by 1, go FETCH.
REQ-026 After an accepted beat with rd_addr==DEPTH-1: go FINISH; rd_addr holds.
REQ-027 FINISH SHALL last one cycle: done=1, busy falls, pass=(err_cnt==0 including the final beat), then IDLE.
REQ-028 An early tlast (before index DEPTH-1) SHALL count as a mismatch and SHALL NOT terminate the frame.
REQ-029 start while busy SHALL be ignored.
REQ-030 s_axis_tvalid while not ARMED SHALL not be accepted and SHALL not affect any state.
REQ-031 Accepted-beat throughput SHALL be one beat per two cycles maximum (FETCH+ARMED).

Reset
REQ-032 rst SHALL, synchronously, force IDLE with rd_addr=0, s_axis_tready=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0.
REQ-033 rst asserted mid-frame SHALL abort the frame without done; next start begins a fresh check at index 0.
REQ-034 rst SHALL take priority over start and over a simultaneously accepted beat.

Verification
REQ-035 Golden frame: ROM {90,81,72,63,54,45,36,27,18,09}, tvalid always 1, tuser matching, tlast on beat 9 -> done pulse ~20 cycles after start, pass=1, err_cnt=0.
REQ-036 Corrupt beat 3 tuser to 0x00 -> err_cnt=1, first_err_addr=3, pass=0.
REQ-037 tlast on beat 4 and missing on beat 9 -> err_cnt=2, first_err_addr=4, frame still runs to beat 9, pass=0.
REQ-038 Random tvalid gaps (tvalid low 0-5 cycles) with golden data -> pass=1; no beat accepted while tready=0.
REQ-039 rst at beat 5, then start -> rd_addr restarts at 0, no done before 10 new beats, err_cnt counts only new frame.
REQ-040 start pulsed during busy and tuser wrong on every beat of a DEPTH=10 frame -> start ignored, err_cnt=10, first_err_addr=0.
